// File: rtl/turfio_cin_tx_pkg.sv
// Shared constants and framing-state encoding for the TURFIO command-in transmitter.
package turfio_cin_tx_pkg;

   typedef logic [31:0] word_t;

   localparam word_t TRAIN_VALUE_DEF = 32'hA55A6996;
   localparam word_t IDLE_WORD       = 32'h00000000;
   localparam int    FRAME_LEN       = 8;
   localparam int    NIBBLE_W        = 4;
   localparam int    KW              = $clog2(FRAME_LEN);

   typedef enum logic [1:0] {
      ST_ALIGN = 2'd0,
      ST_TRAIN = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   // Nibble k of a word, LSB nibble first on the wire.
   function automatic logic [NIBBLE_W-1:0] word_nibble(input word_t w, input logic [KW-1:0] k);
      return w[k*NIBBLE_W +: NIBBLE_W];
   endfunction

endpackage

// File: rtl/turfio_cin_tx_if.sv
// Command push handshake between the command source and the transmitter.
interface turfio_cin_tx_if;
   import turfio_cin_tx_pkg::*;

   word_t command;
   logic  command_valid;
   logic  command_ready;

   modport master (output command, output command_valid, input command_ready);
   modport slave  (input command, input command_valid, output command_ready);

endinterface

// File: rtl/turfio_cin_tx_fifo.sv
// Synchronous command FIFO with registered empty/full/ready and sticky overflow.
module turfio_cin_tx_fifo
   import turfio_cin_tx_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic  clk_i,
   input  logic  rst_n_i,
   input  word_t wr_data_i,
   input  logic  wr_valid_i,
   output logic  wr_ready_o,
   input  logic  rd_i,
   output word_t rd_data_o,
   output logic  empty_o,
   output logic  overflow_o
);

   localparam int AW = $clog2(DEPTH);

   word_t       mem_q [DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic        full_q, full_d, empty_q, ready_q, ovf_q;
   logic        push, pop;

   // Flags are registered, so a pop only frees a slot for pushes on the next cycle.
   assign push     = wr_valid_i && ready_q;
   assign pop      = rd_i && !empty_q;
   assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
   assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
   assign full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         ready_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         full_q   <= full_d;
         empty_q  <= (wr_ptr_d == rd_ptr_d);
         ready_q  <= !full_d;
         ovf_q    <= ovf_q | (wr_valid_i & full_q);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
   end

   assign rd_data_o  = mem_q[rd_ptr_q[AW-1:0]];
   assign wr_ready_o = ready_q;
   assign empty_o    = empty_q;
   assign overflow_o = ovf_q;

endmodule

// File: rtl/turfio_cin_tx.sv
// Serialises 32-bit command/training words into 8 nibbles per clk_phase-aligned frame.
module turfio_cin_tx
   import turfio_cin_tx_pkg::*;
#(
   parameter word_t TRAIN_VALUE = TRAIN_VALUE_DEF,
   parameter int    FIFO_DEPTH  = 4,
   parameter logic  INV_DOUT    = 1'b0
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                clk_phase_i,
   input  logic                train_i,
   turfio_cin_tx_if.slave      cmd_if,
   output logic [NIBBLE_W-1:0] dout_o,
   output logic                phase_ok_o,
   output logic                training_o,
   output logic                overflow_o
);

   state_t              state_q, state_d;
   logic [KW-1:0]       k_q, k_d;
   word_t               word_q, word_d, fifo_head;
   logic [NIBBLE_W-1:0] dout_q, dout_d;
   logic                ok_q, ok_d, seen_q, seen_d;
   logic                fifo_empty, pop, boundary, at_end;

   turfio_cin_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .wr_data_i  (cmd_if.command),
      .wr_valid_i (cmd_if.command_valid),
      .wr_ready_o (cmd_if.command_ready),
      .rd_i       (pop),
      .rd_data_o  (fifo_head),
      .empty_o    (fifo_empty),
      .overflow_o (overflow_o)
   );

   assign at_end = (k_q == KW'(FRAME_LEN - 1));
   assign k_d    = clk_phase_i ? '0 : k_q + KW'(1);

   always_comb begin
      state_d  = state_q;
      word_d   = word_q;
      pop      = 1'b0;
      ok_d     = ok_q;
      seen_d   = seen_q;
      // A phase pulse always starts a new frame, truncating any frame in flight.
      boundary = clk_phase_i || ((state_q != ST_ALIGN) && at_end);
      if (boundary) begin
         if (train_i) begin
            state_d = ST_TRAIN;
            word_d  = TRAIN_VALUE;
         end else begin
            state_d = ST_RUN;
            pop     = !fifo_empty;
            word_d  = fifo_empty ? IDLE_WORD : fifo_head;
         end
      end
      dout_d = (state_d == ST_ALIGN) ? '0 : (word_nibble(word_d, k_d) ^ {NIBBLE_W{INV_DOUT}});

      // Lock needs two pulses exactly one frame apart; any early or missing pulse drops it.
      if (clk_phase_i) begin
         seen_d = 1'b1;
         if (!at_end)     ok_d = 1'b0;
         else if (seen_q) ok_d = 1'b1;
      end else if (at_end) begin
         ok_d   = 1'b0;
         seen_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_ALIGN;
         k_q     <= '0;
         word_q  <= IDLE_WORD;
         dout_q  <= '0;
         ok_q    <= 1'b0;
         seen_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         word_q  <= word_d;
         dout_q  <= dout_d;
         ok_q    <= ok_d;
         seen_q  <= seen_d;
      end
   end

   assign dout_o     = dout_q;
   assign phase_ok_o = ok_q;
   assign training_o = (state_q == ST_TRAIN);

endmodule

// File: tb/tb_turfio_cin_tx.sv
// Directed bench for turfio_cin_tx with a queue-based frame model checked every cycle.
module tb_turfio_cin_tx;
   import turfio_cin_tx_pkg::*;

   localparam int    DEPTH = 4;
   localparam word_t TV    = 32'hA55A6996;

   logic       clk = 1'b0, rst_n = 1'b0, clk_phase = 1'b0, train = 1'b0;
   logic [3:0] dout;
   logic       phase_ok, training, overflow;
   int         errors = 0, checks = 0;
   int         pc = 0;

   turfio_cin_tx_if cif();

   turfio_cin_tx #(.TRAIN_VALUE(TV), .FIFO_DEPTH(DEPTH), .INV_DOUT(1'b0)) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .clk_phase_i (clk_phase),
      .train_i     (train),
      .cmd_if      (cif),
      .dout_o      (dout),
      .phase_ok_o  (phase_ok),
      .training_o  (training),
      .overflow_o  (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: frames are 8 edges long, counted from the most recent phase pulse.
   word_t mq[$];
   bit    m_al, m_tr, m_rdy, m_ovf, m_ok, m_lpv;
   word_t m_word;
   int    m_es;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         m_al = 0; m_tr = 0; m_rdy = 0; m_ovf = 0; m_ok = 0; m_lpv = 0;
         m_word = 0; m_es = 0;
      end else begin
         int n;
         bit bnd;
         n = mq.size();
         if (clk_phase) begin
            m_ok  = m_lpv && (m_es + 1 == 8);
            m_lpv = 1;
            m_es  = 0;
         end else if (m_lpv) begin
            m_es++;
            if (m_es == 8) m_ok = 0;
         end
         bnd = clk_phase || (m_al && (m_es % 8 == 0));
         if (bnd) begin
            m_tr = train;
            if (train)      m_word = TV;
            else if (n > 0) m_word = mq.pop_front();
            else            m_word = 32'h0;
         end
         m_al = m_al || clk_phase;
         if (cif.command_valid && n == DEPTH) m_ovf = 1;
         if (cif.command_valid && m_rdy) mq.push_back(cif.command);
         m_rdy = (mq.size() < DEPTH);
      end
   end

   function automatic logic [3:0] exp_dout();
      return m_al ? m_word[4*(m_es % 8) +: 4] : 4'h0;
   endfunction

   always @(negedge clk) begin
      chk("dout", {28'h0, dout}, {28'h0, exp_dout()});
      chk("training", {31'h0, training}, {31'h0, m_al && m_tr});
      chk("ready", {31'h0, cif.command_ready}, {31'h0, m_rdy});
      chk("phase_ok", {31'h0, phase_ok}, {31'h0, m_ok});
      chk("overflow", {31'h0, overflow}, {31'h0, m_ovf});
   end

   task automatic tick();
      @(negedge clk);
      pc++;
      clk_phase = (pc % 8 == 0);
   endtask

   task automatic to_phase();
      for (int i = 0; i < 8; i++) begin
         tick();
         if (clk_phase) break;
      end
   endtask

   task automatic push(input word_t w);
      cif.command       = w;
      cif.command_valid = 1'b1;
      tick();
      cif.command_valid = 1'b0;
   endtask

   // seq lists the expected nibbles in transmit order, first nibble in the top digit.
   task automatic frame_lit(input string name, input logic [31:0] seq);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk(name, {28'h0, dout}, {28'h0, seq[31-4*i -: 4]});
      end
   endtask

   initial begin
      cif.command       = 32'h0;
      cif.command_valid = 1'b0;
      train             = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_ready", {31'h0, cif.command_ready}, 32'h0);
      chk("rst_dout", {28'h0, dout}, 32'h0);
      rst_n = 1'b1;

      // Training frames and phase lock
      to_phase();
      to_phase();
      frame_lit("train_frame", 32'h6996A55A);
      chk("train_ok", {31'h0, phase_ok}, 32'h1);
      chk("train_flag", {31'h0, training}, 32'h1);

      // Single command then idle
      train = 1'b0;
      tick();
      push(32'h12345678);
      to_phase();
      frame_lit("cmd_frame", 32'h87654321);
      frame_lit("idle_frame", 32'h00000000);

      // Overfill while training holds the FIFO
      train = 1'b1;
      tick();
      cif.command_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cif.command = 32'hA0B1C2D0 + i;
         tick();
      end
      cif.command_valid = 1'b0;
      chk("full_ready", {31'h0, cif.command_ready}, 32'h0);
      chk("ovf_set", {31'h0, overflow}, 32'h1);
      train = 1'b0;
      to_phase();
      frame_lit("fifo_w0", 32'h0D2C1B0A);
      frame_lit("fifo_w1", 32'h1D2C1B0A);
      frame_lit("fifo_w2", 32'h2D2C1B0A);
      frame_lit("fifo_w3", 32'h3D2C1B0A);
      frame_lit("fifo_drained", 32'h00000000);

      // Mid-frame train toggles take effect at the next boundary
      repeat (4) tick();
      train = 1'b1;
      push(32'h5A5A0F0F);
      to_phase();
      frame_lit("toggle_train", 32'h6996A55A);
      repeat (4) tick();
      train = 1'b0;
      chk("mid_training", {31'h0, training}, 32'h1);
      to_phase();
      frame_lit("toggle_run", 32'hF0F0A5A5);

      // Early phase pulse truncates an in-flight command and drops lock
      tick();
      push(32'h000000FF);
      to_phase();
      tick();
      tick();
      tick();
      pc += 3;
      to_phase();
      tick();
      chk("ok_drop", {31'h0, phase_ok}, 32'h0);
      chk("trunc_idle", {28'h0, dout}, 32'h0);
      to_phase();
      tick();
      chk("ok_back", {31'h0, phase_ok}, 32'h1);

      // Reset mid-frame with two queued words
      train = 1'b1;
      push(32'h11112222);
      push(32'h33334444);
      to_phase();
      repeat (5) tick();
      #2 rst_n = 1'b0;
      #1;
      chk("arst_dout", {28'h0, dout}, 32'h0);
      chk("arst_ready", {31'h0, cif.command_ready}, 32'h0);
      chk("arst_training", {31'h0, training}, 32'h0);
      chk("arst_ok", {31'h0, phase_ok}, 32'h0);
      chk("arst_ovf", {31'h0, overflow}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      train = 1'b0;

      // Push on the boundary with an empty FIFO goes out one frame later
      to_phase();
      cif.command       = 32'hDEADBEEF;
      cif.command_valid = 1'b1;
      tick();
      cif.command_valid = 1'b0;
      chk("empty_push_idle", {28'h0, dout}, 32'h0);
      to_phase();
      frame_lit("empty_push_sent", 32'hFEEBDAED);
      repeat (4) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
